presc_seq: RTL and testbench
============================

PRESC_SEQ -- requirements
Module: presc_seq

Interface
REQ-001 SHALL have parameter NB, default 22, meaning base prescaler width in bits, so the tick period is 2^NB clock cycles (NB >= 1).
REQ-002 SHALL have parameter BURST, default 8, meaning full square-wave periods emitted on each pin per slot (BURST >= 1).
REQ-003 SHALL have port CLK_IN  input  1  system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RST_IN  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  level, sampled on CLK_IN; starts a sweep when the block is idle.
REQ-006 SHALL have port STOP  input  1  level, sampled on CLK_IN; aborts a sweep.
REQ-007 SHALL have ports PIN_1, PIN_2, PIN_3, PIN_4  output  1 each  divided square-wave outputs, registered.
REQ-008 SHALL have port CH  output  2  index of the active pin (0 = PIN_1 ... 3 = PIN_4), registered.
REQ-009 SHALL have port BUSY  output  1  high while in RUN, registered.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse marking sweep completion, registered.

Function
REQ-011 SHALL implement a state machine with states IDLE and RUN; the block shares one base prescaler counter across all four pins.
REQ-012 In IDLE: base counter = 0, toggle counter = 0, CH = 0, all PINs = 0, BUSY = 0.
REQ-013 IDLE -> RUN on the edge where START = 1 and STOP = 0; BUSY goes to 1 on that edge.
REQ-014 In RUN, the base counter SHALL increment every cycle and wrap from 2^NB-1 to 0; the wrap edge is a tick.
REQ-015 On each tick, the pin selected by CH SHALL toggle, and the toggle counter SHALL increment; all other PINs SHALL stay 0.
REQ-016 The first PIN_1 rising edge SHALL occur 2^NB edges after BUSY rises.
REQ-017 When a tick brings the toggle counter to 2*BURST, the active pin SHALL end low, the toggle counter SHALL reset to 0, and CH SHALL advance 0->1->2->3 on that same edge.
REQ-018 One slot SHALL last exactly 2*BURST*2^NB cycles; one full sweep SHALL last 8*BURST*2^NB cycles.
REQ-019 Sweep end is the final toggle of slot CH = 3; the behaviour at sweep end is set by REQ-026/REQ-027.
REQ-020 STOP = 1 sampled in RUN SHALL force IDLE on that edge with all PINs = 0, CH = 0, BUSY = 0, DONE = 0 (abort, no DONE).
REQ-021 If START and STOP are both 1 in IDLE, STOP SHALL win and the block SHALL remain IDLE.
REQ-022 START while in RUN SHALL be ignored, with no restart of counters.
REQ-023 If START is still high at sweep end in non-loop mode, a new sweep SHALL begin only from the next IDLE sample, one cycle later.

Reset
REQ-024 RST_IN = 1 SHALL immediately, without waiting for a clock edge, force IDLE with counters = 0, PIN_1..PIN_4 = 0, CH = 0, BUSY = 0, DONE = 0; this applies mid-sweep as well.
REQ-025 After RST_IN deasserts, the block SHALL remain IDLE until START is sampled high.

Configuration
REQ-026 Macro PRESC_SEQ_LOOP_EN defined: at sweep end, CH SHALL wrap to 0, the block SHALL stay in RUN (BUSY stays 1), and DONE SHALL pulse for 1 cycle per completed sweep; operation continues until STOP or RST_IN.
REQ-027 Macro PRESC_SEQ_LOOP_EN undefined: at sweep end, the block SHALL enter IDLE on that edge, with DONE = 1 for exactly that one cycle while BUSY falls to 0 and CH returns to 0.

Verification (NB = 2, BURST = 2 unless stated)
REQ-028 Reset then START pulse -> BUSY = 1 next edge; PIN_1 rises 4 cycles later; PIN_1 shows 2 periods of 8 cycles; CH then becomes 1 and PIN_2 repeats the pattern.
REQ-029 Loop undefined, full sweep -> DONE is a single-cycle pulse exactly 64 cycles after BUSY rose; BUSY = 0 in the same cycle; all PINs = 0.
REQ-030 Loop defined, run 150 cycles -> DONE pulses at cycles 64 and 128 after BUSY rose; CH wraps 3->0; BUSY stays 1.
REQ-031 STOP asserted mid-slot on CH = 2 with PIN_3 = 1 -> next edge PIN_3 = 0, CH = 0, BUSY = 0, DONE never pulses.
REQ-032 START = STOP = 1 in IDLE -> state stays IDLE, BUSY = 0; RST_IN pulsed asynchronously between edges mid-sweep -> all outputs 0 before the next CLK_IN edge.
REQ-033 NB = 1, BURST = 1 -> each pin is high 2 cycles and low 2 cycles; the sweep completes in 16 cycles.

Source files
------------

// File: rtl/presc_seq.sv
// presc_seq: a four-pin sequenced square-wave generator.
// One shared base prescaler of NB bits produces a tick every 2^NB cycles.
// Each tick toggles the pin selected by CH. After 2*BURST toggles (BURST full
// periods), that pin ends low and CH moves on to the next pin.
// A sweep covers PIN_1..PIN_4 in turn.
// Optional feature: define PRESC_SEQ_LOOP_EN to restart the sweep continuously.
// In that mode DONE pulses once per completed sweep. With the macro undefined
// the block returns to IDLE at the end of the sweep.
module presc_seq #(
    parameter int NB    = 22,
    parameter int BURST = 8
) (
    input  logic       CLK_IN,
    input  logic       RST_IN,
    input  logic       START,
    input  logic       STOP,
    output logic       PIN_1,
    output logic       PIN_2,
    output logic       PIN_3,
    output logic       PIN_4,
    output logic [1:0] CH,
    output logic       BUSY,
    output logic       DONE
);

    // Toggle counter must hold values up to 2*BURST-1.
    localparam int            TW       = $clog2(2 * BURST + 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * BURST - 1);
    localparam logic [NB-1:0] BASE_MAX = {NB{1'b1}};
    localparam logic [1:0]    CH_LAST  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [NB-1:0] base_cnt_r;
    logic [NB-1:0] base_cnt_nxt_s;
    logic [TW-1:0] tog_cnt_r;
    logic [TW-1:0] tog_cnt_nxt_s;
    logic [1:0]    ch_r;
    logic [1:0]    ch_nxt_s;
    logic [3:0]    pin_r;
    logic [3:0]    pin_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          done_r;
    logic          done_nxt_s;
    logic          go_s;
    logic          tick_s;
    logic          slot_end_s;
    logic          sweep_end_s;

    // Decode the start request and the tick/slot/sweep boundaries from the counters
    always_comb begin
        go_s        = START & ~STOP;
        tick_s      = (base_cnt_r == BASE_MAX);
        slot_end_s  = tick_s & (tog_cnt_r == TOG_LAST);
        sweep_end_s = slot_end_s & (ch_r == CH_LAST);
    end

    // State register; reset acts immediately, independent of the clock
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: STOP always wins; at sweep end either loop or go idle
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_nxt_s = ST_IDLE;
                end else if (sweep_end_s) begin
`ifdef PRESC_SEQ_LOOP_EN
                    state_nxt_s = ST_RUN;
`else
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/counter next values; the defaults are the idle (all-zero) values
    always_comb begin
        base_cnt_nxt_s = '0;
        tog_cnt_nxt_s  = '0;
        ch_nxt_s       = 2'd0;
        pin_nxt_s      = 4'b0000;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    busy_nxt_s = 1'b0;
                end else begin
                    busy_nxt_s     = 1'b1;
                    base_cnt_nxt_s = base_cnt_r + NB'(1);
                    tog_cnt_nxt_s  = tog_cnt_r;
                    ch_nxt_s       = ch_r;
                    pin_nxt_s      = pin_r;
                    if (slot_end_s) begin
                        // Last toggle of the slot: pin ends low, move to next pin
                        pin_nxt_s     = 4'b0000;
                        tog_cnt_nxt_s = '0;
                        ch_nxt_s      = ch_r + 2'd1;
                        if (sweep_end_s) begin
                            done_nxt_s = 1'b1;
`ifdef PRESC_SEQ_LOOP_EN
                            busy_nxt_s = 1'b1;
`else
                            busy_nxt_s = 1'b0;
`endif
                        end else begin
                            done_nxt_s = 1'b0;
                        end
                    end else if (tick_s) begin
                        pin_nxt_s[ch_r] = ~pin_r[ch_r];
                        tog_cnt_nxt_s   = tog_cnt_r + TW'(1);
                    end else begin
                        tog_cnt_nxt_s = tog_cnt_r;
                    end
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and counters; reset clears everything at once
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            base_cnt_r <= '0;
            tog_cnt_r  <= '0;
            ch_r       <= 2'd0;
            pin_r      <= 4'b0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            base_cnt_r <= base_cnt_nxt_s;
            tog_cnt_r  <= tog_cnt_nxt_s;
            ch_r       <= ch_nxt_s;
            pin_r      <= pin_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign PIN_1 = pin_r[0];
    assign PIN_2 = pin_r[1];
    assign PIN_3 = pin_r[2];
    assign PIN_4 = pin_r[3];
    assign CH    = ch_r;
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule

// File: tb/tb_presc_seq.sv
// tb_presc_seq: drives two presc_seq instances (NB=2/BURST=2 and NB=1/BURST=1)
// with the same START/STOP/RST_IN stimulus.
// A reference model computes the expected outputs from the elapsed time within
// the sweep. It pushes one expected output vector per clock into a queue for
// each instance. A monitor pops those entries on the falling edge and compares
// them with the instance outputs.
module tb_presc_seq;

    logic       CLK_IN = 1'b0;
    logic       RST_IN = 1'b1;
    logic       START  = 1'b0;
    logic       STOP   = 1'b0;

    logic       a_p1, a_p2, a_p3, a_p4, a_busy, a_done;
    logic [1:0] a_ch;
    logic       b_p1, b_p2, b_p3, b_p4, b_busy, b_done;
    logic [1:0] b_ch;

    int errors = 0;
    int checks = 0;

`ifdef PRESC_SEQ_LOOP_EN
    localparam bit LOOP_M = 1'b1;
`else
    localparam bit LOOP_M = 1'b0;
`endif

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    bit         run_m[2];
    int         t_m[2];
    bit         done_m[2];
    int         rst_cnt  = 0;
    int         rst_seen = 0;

    presc_seq #(.NB(2), .BURST(2)) u_a (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .START(START), .STOP(STOP),
        .PIN_1(a_p1), .PIN_2(a_p2), .PIN_3(a_p3), .PIN_4(a_p4),
        .CH(a_ch), .BUSY(a_busy), .DONE(a_done)
    );

    presc_seq #(.NB(1), .BURST(1)) u_b (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .START(START), .STOP(STOP),
        .PIN_1(b_p1), .PIN_2(b_p2), .PIN_3(b_p3), .PIN_4(b_p4),
        .CH(b_ch), .BUSY(b_busy), .DONE(b_done)
    );

    wire [7:0] dut_a = {a_done, a_busy, a_ch, a_p4, a_p3, a_p2, a_p1};
    wire [7:0] dut_b = {b_done, b_busy, b_ch, b_p4, b_p3, b_p2, b_p1};

    always #5 CLK_IN = ~CLK_IN;

    // Tick period in cycles for each instance
    function automatic int per_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Slot length in cycles: 2*BURST ticks
    function automatic int slot_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    // Expected output vector {DONE,BUSY,CH,PIN_4..PIN_1} derived from elapsed sweep time
    function automatic logic [7:0] expv(input int i);
        logic [7:0] v;
        int idx;
        int k;
        v = 8'h00;
        if (run_m[i]) begin
            idx = (t_m[i] / slot_of(i)) % 4;
            k   = (t_m[i] % slot_of(i)) / per_of(i);
            v[6]   = 1'b1;
            v[5:4] = idx[1:0];
            if (k % 2 == 1) v[idx] = 1'b1;
        end
        v[7] = done_m[i];
        return v;
    endfunction

    // One clock of behaviour: t counts edges since BUSY rose
    task automatic model_step(input int i);
        done_m[i] = 1'b0;
        if (!run_m[i]) begin
            if (START && !STOP) begin
                run_m[i] = 1'b1;
                t_m[i]   = 0;
            end
        end else if (STOP) begin
            run_m[i] = 1'b0;
            t_m[i]   = 0;
        end else begin
            t_m[i] = t_m[i] + 1;
            if (t_m[i] == 4 * slot_of(i)) begin
                done_m[i] = 1'b1;
                t_m[i]    = 0;
                if (!LOOP_M) run_m[i] = 1'b0;
            end
        end
    endtask

    // Count asynchronous reset assertions so the model sees pulses between edges
    always @(posedge RST_IN) rst_cnt = rst_cnt + 1;

    // Reference model: advance on each rising edge, push expected outputs
    always @(posedge CLK_IN) begin
        if (RST_IN) begin
            for (int i = 0; i < 2; i++) begin
                run_m[i] = 1'b0; t_m[i] = 0; done_m[i] = 1'b0;
            end
            rst_seen = rst_cnt;
            q_a.push_back(8'h00);
            q_b.push_back(8'h00);
        end else begin
            if (rst_seen != rst_cnt) begin
                for (int i = 0; i < 2; i++) begin
                    run_m[i] = 1'b0; t_m[i] = 0; done_m[i] = 1'b0;
                end
                rst_seen = rst_cnt;
            end
            for (int i = 0; i < 2; i++) model_step(i);
            q_a.push_back(expv(0));
            q_b.push_back(expv(1));
        end
    end

    // Monitor: compare on falling edges; check immediate clearing on reset rise
    initial begin
        logic       rst_prev;
        logic [7:0] e;
        rst_prev = 1'b1;
        forever begin
            @(negedge CLK_IN or posedge RST_IN);
            if (RST_IN && !rst_prev) begin
                #1;
                checks = checks + 1;
                if (dut_a !== 8'h00 || dut_b !== 8'h00) begin
                    errors = errors + 1;
                    $display("FAIL async_rst t=%0t got a=%b b=%b exp=00000000", $time, dut_a, dut_b);
                end
            end else if (q_a.size() > 0 && q_b.size() > 0) begin
                e = q_a.pop_front();
                checks = checks + 1;
                if (dut_a !== e) begin
                    errors = errors + 1;
                    $display("FAIL outs_a t=%0t got=%b exp=%b", $time, dut_a, e);
                end
                e = q_b.pop_front();
                checks = checks + 1;
                if (dut_b !== e) begin
                    errors = errors + 1;
                    $display("FAIL outs_b t=%0t got=%b exp=%b", $time, dut_b, e);
                end
            end
            rst_prev = RST_IN;
        end
    end

    task automatic cyc(input logic s, input logic p);
        @(negedge CLK_IN);
        START = s;
        STOP  = p;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    // Pulse reset between clock edges
    task automatic async_rst();
        @(negedge CLK_IN);
        START = 1'b0;
        STOP  = 1'b0;
        #2 RST_IN = 1'b1;
        #2 RST_IN = 1'b0;
    endtask

    // Stimulus
    initial begin
        int r;
        repeat (3) @(negedge CLK_IN);
        RST_IN = 1'b0;
        idle_n(3);
        // Single START pulse, full sweep on both instances
        cyc(1'b1, 1'b0);
        idle_n(150);
        // Abort on CH=2 while PIN_3 is high (t=37 for the NB=2 instance)
        cyc(1'b1, 1'b0);
        idle_n(37);
        cyc(1'b0, 1'b1);
        idle_n(5);
        // START and STOP together while idle
        repeat (4) cyc(1'b1, 1'b1);
        idle_n(3);
        // START held across sweep end
        repeat (70) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        idle_n(3);
        // Asynchronous reset mid-sweep
        cyc(1'b1, 1'b0);
        idle_n(20);
        async_rst();
        idle_n(5);
        // Randomized traffic
        repeat (800) begin
            r = $urandom_range(0, 99);
            if (r < 2) async_rst();
            else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end
        cyc(1'b0, 1'b1);
        idle_n(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
